// File: rtl/seq_deser_buf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_deser_buf_pkg
//  Description : Shared word-format defaults, FSM encoding and width helper
//                for the serial product deserializer.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_deser_buf_pkg;

    // Word format shared with the upstream serial multiplier: S(4,3)
    localparam int NB_DATA_DEF  = 4;
    localparam int NBF_DATA_DEF = 3;

    // Frame FSM encoding
    typedef enum logic [0:0] {
        ST_HUNT    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

    // Width able to hold the values 0..n inclusive (bit counter, FIFO level)
    function automatic int f_width(input int n);
        return $clog2(n) + 1;
    endfunction

    localparam int CNT_W_DEF = f_width(NB_DATA_DEF);

endpackage
`default_nettype wire

// File: rtl/seq_deser_buf_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Small single-clock first-word-fall-through FIFO. Pointers
//                carry one extra MSB so full and empty are distinguishable.
//                The head output holds the last popped word while empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
    import seq_deser_buf_pkg::*;
#(
    parameter int NB_DATA    = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_push,
    input  logic                             i_pop,
    input  logic [NB_DATA-1:0]               i_data,
    output logic                             o_full,
    output logic                             o_empty,
    output logic [f_width(FIFO_DEPTH)-1:0]   o_level,
    output logic [NB_DATA-1:0]               o_data
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [NB_DATA-1:0] r_mem [FIFO_DEPTH];
    logic [NB_DATA-1:0] r_last;

    logic [PW-1:0]      w_level;
    logic               w_full;
    logic               w_empty;
    logic               w_do_pop;
    logic               w_do_push;

    assign w_level   = r_wr_ptr - r_rd_ptr;
    assign w_full    = (w_level == PW'(FIFO_DEPTH));
    assign w_empty   = (w_level == '0);
    assign w_do_pop  = i_pop && !w_empty;
    // A push into a full FIFO is accepted only when a pop frees the slot on the same edge
    assign w_do_push = i_push && (!w_full || w_do_pop);

    // Storage, pointer advance and last-popped word capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_last   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_data;
                r_wr_ptr                <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_last   <= r_mem[r_rd_ptr[AW-1:0]];
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_level = w_level;
    assign o_data  = w_empty ? r_last : r_mem[r_rd_ptr[AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/seq_deser_buf.sv
`default_nettype none
// ============================================================================
//  Module      : seq_deser_buf
//  Description : Reassembles the LSB-first serial product stream into parallel
//                words, aligned by a sync pulse on bit 0, and buffers them in
//                a FIFO with a valid/ready output handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_deser_buf
    import seq_deser_buf_pkg::*;
#(
    parameter int NB_DATA    = NB_DATA_DEF,
    parameter int NBF_DATA   = NBF_DATA_DEF,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                             clock,
    input  logic                             i_rst,
    input  logic                             i_en,
    input  logic                             i_data,
    input  logic                             i_sync,
    output logic [NB_DATA-1:0]               o_data,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic                             o_frame_err,
    output logic                             o_overflow,
    output logic [f_width(FIFO_DEPTH)-1:0]   o_level
);

    localparam int CNT_W = f_width(NB_DATA);

    // Elaboration-time parameter sanity checks
    generate
        if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("FIFO_DEPTH must be a power of 2 and at least 2");
        end
        if ((NBF_DATA < 0) || (NBF_DATA >= NB_DATA)) begin : g_bad_frac
            $error("NBF_DATA must lie in 0..NB_DATA-1");
        end
    endgenerate

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [NB_DATA-1:0] r_shreg;
    logic [NB_DATA-1:0] w_shreg_nxt;
    logic               r_frame_err;
    logic               w_frame_err;
    logic               r_overflow;
    logic               w_push;

    logic               w_full;
    logic               w_empty;
    logic               w_pop;

    // Next-state, bit placement, word-complete push and frame-error detection
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shreg_nxt = r_shreg;
        w_push      = 1'b0;
        w_frame_err = 1'b0;
        if (i_en) begin
            case (r_state)
                ST_HUNT: begin
                    if (i_sync) begin
                        w_shreg_nxt    = '0;
                        w_shreg_nxt[0] = i_data;
                        w_cnt_nxt      = CNT_W'(1);
                        w_state_nxt    = ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (r_cnt == CNT_W'(NB_DATA)) begin
                        // Previous word just completed: only a sync keeps the frame running
                        if (i_sync) begin
                            w_shreg_nxt    = '0;
                            w_shreg_nxt[0] = i_data;
                            w_cnt_nxt      = CNT_W'(1);
                        end else begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = ST_HUNT;
                        end
                    end else if (i_sync) begin
                        // Sync inside a word: drop the partial word and realign
                        w_frame_err    = 1'b1;
                        w_shreg_nxt    = '0;
                        w_shreg_nxt[0] = i_data;
                        w_cnt_nxt      = CNT_W'(1);
                    end else begin
                        w_shreg_nxt[r_cnt[CNT_W-2:0]] = i_data;
                        w_cnt_nxt                     = r_cnt + 1'b1;
                        if (r_cnt == CNT_W'(NB_DATA - 1)) begin
                            w_push = 1'b1;
                        end
                    end
                end
                default: begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_HUNT;
                end
            endcase
        end
    end

    // Capture-side state registers and status flags
    always_ff @(posedge clock) begin
        if (i_rst) begin
            r_state     <= ST_HUNT;
            r_cnt       <= '0;
            r_shreg     <= '0;
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_shreg     <= w_shreg_nxt;
            r_frame_err <= w_frame_err;
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign w_pop = !w_empty && i_ready;

    sync_fifo #(
        .NB_DATA    (NB_DATA),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clock),
        .rst     (i_rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_shreg_nxt),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (o_level),
        .o_data  (o_data)
    );

    assign o_valid     = !w_empty;
    assign o_frame_err = r_frame_err;
    assign o_overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_seq_deser_buf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_deser_buf
//  Description : Directed self-checking bench for seq_deser_buf (defaults:
//                NB_DATA=4, FIFO_DEPTH=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_deser_buf;

    logic       clock;
    logic       i_rst;
    logic       i_en;
    logic       i_data;
    logic       i_sync;
    logic       i_ready;
    logic [3:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_overflow;
    logic [1:0] o_level;

    int total = 0;
    int bad   = 0;

    seq_deser_buf dut (
        .clock       (clock),
        .i_rst       (i_rst),
        .i_en        (i_en),
        .i_data      (i_data),
        .i_sync      (i_sync),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_frame_err (o_frame_err),
        .o_overflow  (o_overflow),
        .o_level     (o_level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Present one cycle of inputs, let the edge happen, settle 1ns after it
    task automatic cyc(input logic en, input logic d, input logic s);
        i_en   = en;
        i_data = d;
        i_sync = s;
        @(posedge clock);
        #1;
    endtask

    // Send a full word LSB first, sync on bit 0, no gaps
    task automatic send_word(input logic [3:0] w);
        for (int b = 0; b < 4; b++) begin
            cyc(1'b1, w[b], (b == 0));
        end
    endtask

    initial begin
        i_rst = 1'b1; i_en = 1'b0; i_data = 1'b0; i_sync = 1'b0; i_ready = 1'b0;
        @(posedge clock); #1;
        cyc(1'b0, 1'b0, 1'b0);
        i_rst = 1'b0;

        // Reset state
        chk("rst_valid", o_valid, 0);
        chk("rst_data", o_data, 0);
        chk("rst_ferr", o_frame_err, 0);
        chk("rst_ovf", o_overflow, 0);
        chk("rst_level", o_level, 0);

        // Single word 1010 with consumer ready
        i_ready = 1'b1;
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("single_pre_valid", o_valid, 0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("single_valid", o_valid, 1);
        chk("single_data", o_data, 4'b1010);
        cyc(1'b0, 1'b0, 1'b0);
        chk("single_one_cycle", o_valid, 0);

        // Back-to-back 0011, 1111 while stalled, then drain
        i_ready = 1'b0;
        send_word(4'b0011);
        send_word(4'b1111);
        chk("b2b_level", o_level, 2);
        chk("b2b_head", o_data, 4'b0011);
        i_ready = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        chk("b2b_pop1_data", o_data, 4'b1111);
        chk("b2b_pop1_level", o_level, 1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("b2b_empty", o_valid, 0);
        chk("b2b_hold_data", o_data, 4'b1111);
        chk("b2b_no_ovf", o_overflow, 0);

        // Overflow: third word dropped while full
        i_ready = 1'b0;
        send_word(4'b0001);
        send_word(4'b0010);
        chk("ovf_level_full", o_level, 2);
        chk("ovf_not_yet", o_overflow, 0);
        send_word(4'b0100);
        chk("ovf_set", o_overflow, 1);
        chk("ovf_level", o_level, 2);
        chk("ovf_head", o_data, 4'b0001);
        i_ready = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        chk("ovf_drain2", o_data, 4'b0010);
        chk("ovf_sticky", o_overflow, 1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("ovf_drained", o_valid, 0);
        chk("ovf_sticky2", o_overflow, 1);

        // Mid-word sync: partial 11 discarded, 0100 delivered
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b0);
        chk("mid_ferr_pre", o_frame_err, 0);
        cyc(1'b1, 1'b0, 1'b1);
        chk("mid_ferr", o_frame_err, 1);
        chk("mid_no_word", o_valid, 0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("mid_ferr_pulse", o_frame_err, 0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("mid_no_word2", o_valid, 0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("mid_valid", o_valid, 1);
        chk("mid_data", o_data, 4'b0100);
        chk("mid_level", o_level, 1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("mid_only_one", o_valid, 0);

        // Stall: i_en low between bits, with garbage on data/sync meanwhile
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("stall_pre", o_valid, 0);
        chk("stall_no_ferr", o_frame_err, 0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("stall_valid", o_valid, 1);
        chk("stall_data", o_data, 4'b0110);
        cyc(1'b0, 1'b1, 1'b1);
        chk("stall_popped", o_valid, 0);

        // Reset mid-operation with one word queued and overflow still set
        i_ready = 1'b0;
        send_word(4'b0001);
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b0);
        chk("prerst_level", o_level, 1);
        i_rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        i_rst = 1'b0;
        chk("midrst_valid", o_valid, 0);
        chk("midrst_level", o_level, 0);
        chk("midrst_ovf", o_overflow, 0);
        chk("midrst_data", o_data, 0);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 1'b1, 1'b0);
        end
        chk("hunt_ignore_valid", o_valid, 0);
        chk("hunt_ignore_level", o_level, 0);
        send_word(4'b1011);
        chk("after_rst_valid", o_valid, 1);
        chk("after_rst_data", o_data, 4'b1011);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
